// File: rtl/av2_recon_pack_writer.sv
// Reconstruction write-back packer: packs multi-lane pixel beats into BUS_W words with strided row addressing.
// Optional build macro AV2_RECON_CLIP_EN selects lane clipping instead of truncation.
module av2_recon_pack_writer #(
  parameter int PIX_W    = 8,
  parameter int IN_LANES = 4,
  parameter int BUS_W    = 128,
  parameter int ADDR_W   = 32,
  parameter int DIM_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIM_W-1:0]              blk_width,
  input  logic [DIM_W-1:0]              blk_height,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W-1:0]             stride,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [IN_LANES*(PIX_W+2)-1:0] pix_data,
  output logic [BUS_W-1:0]              wr_data,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          wr_en,
  input  logic                          wr_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int LANE_W = PIX_W + 2;
  localparam int PPW    = BUS_W / PIX_W;
  localparam int BPW    = BUS_W / 8;
  localparam int BEATS  = PPW / IN_LANES;
  localparam int FILL_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [DIM_W-1:0]    r_width, r_height, r_row, r_col;
  logic [ADDR_W-1:0]   r_stride, r_row_addr, r_cur_addr;
  logic [FILL_W-1:0]   r_fill;
  logic [BUS_W-1:0]    r_acc, w_acc_next;
  logic [BUS_W-1:0]    r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_wr_en;
  logic                w_accept, w_row_end, w_word_full, w_complete, w_last_row;
  logic [DIM_W:0]      w_col_next;

  function automatic logic [PIX_W-1:0] f_lane(input logic [LANE_W-1:0] v);
`ifdef AV2_RECON_CLIP_EN
    if (v[LANE_W-1])               return '0;
    else if (|v[LANE_W-2:PIX_W])   return '1;
    else                           return v[PIX_W-1:0];
`else
    return v[PIX_W-1:0];
`endif
  endfunction

  assign pix_ready   = (r_state == S_RUN) && (!r_wr_en || wr_ready);
  assign w_accept    = pix_valid && pix_ready;
  assign w_col_next  = {1'b0, r_col} + (DIM_W+1)'(IN_LANES);
  assign w_row_end   = (w_col_next == {1'b0, r_width});
  assign w_word_full = (r_fill == FILL_W'(BEATS - 1));
  assign w_complete  = w_accept && (w_row_end || w_word_full);
  assign w_last_row  = (r_row == r_height - DIM_W'(1));

  // Lanes land in the next free slots; untouched upper slots stay zero, which is the row-end padding.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_acc_next = r_acc;
    for (int i = 0; i < IN_LANES; i++)
      w_acc_next[(int'(r_fill)*IN_LANES + i)*PIX_W +: PIX_W] = f_lane(pix_data[i*LANE_W +: LANE_W]);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (blk_width == '0 || blk_height == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && w_row_end && w_last_row) w_state_next = S_DRAIN;
      S_DRAIN: if (r_wr_en && wr_ready) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_height   <= '0;
      r_stride   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_fill     <= '0;
      r_acc      <= '0;
      r_row_addr <= '0;
      r_cur_addr <= '0;
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_width    <= blk_width;
        r_height   <= blk_height;
        r_stride   <= stride;
        r_row      <= '0;
        r_col      <= '0;
        r_fill     <= '0;
        r_acc      <= '0;
        r_row_addr <= base_addr;
        r_cur_addr <= base_addr;
      end
      if (w_complete) begin
        r_wr_data <= w_acc_next;
        r_wr_addr <= r_cur_addr;
        r_wr_en   <= 1'b1;
      end else if (wr_ready) begin
        r_wr_en <= 1'b0;
      end
      if (w_accept) begin
        if (w_complete) begin
          r_acc  <= '0;
          r_fill <= '0;
        end else begin
          r_acc  <= w_acc_next;
          r_fill <= r_fill + FILL_W'(1);
        end
        if (w_row_end) begin
          r_col      <= '0;
          r_row      <= r_row + DIM_W'(1);
          r_row_addr <= r_row_addr + r_stride;
          r_cur_addr <= r_row_addr + r_stride;
        end else begin
          r_col <= w_col_next[DIM_W-1:0];
          if (w_word_full) r_cur_addr <= r_cur_addr + ADDR_W'(BPW);
        end
      end
    end
  end

  assign wr_data = r_wr_data;
  assign wr_addr = r_wr_addr;
  assign wr_en   = r_wr_en;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule

// File: doc/av2_recon_pack_writer.md
Name: av2_recon_pack_writer

Overview:
Parametrised reconstruction write-back packer for the AV2 tile decoder datapath. It accepts reconstructed pixels as a multi-lane valid/ready stream in raster order and packs them into BUS_W-wide frame-buffer words. It generates per-row strided addresses and drives a write port with backpressure. It replaces the fixed 16×8-bit recon_data/recon_addr/recon_wr_en output with configurable pixel width, lane count and bus width, plus row-end padding.

Parameters:
PIX_W, 8, stored pixel width in bits (8 or 16)
IN_LANES, 4, pixels accepted per input beat
BUS_W, 128, write data width; must be a multiple of PIX_W*IN_LANES
ADDR_W, 32, address width
DIM_W, 16, width of the block dimension inputs

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches configuration in IDLE
blk_width  input  DIM_W  pixels per row; must be a multiple of IN_LANES
blk_height  input  DIM_W  rows
base_addr  input  ADDR_W  byte address of pixel (0,0)
stride  input  ADDR_W  byte distance between rows
pix_valid  input  1  input beat valid
pix_ready  output  1  input beat accepted when valid&ready
pix_data  input  IN_LANES*(PIX_W+2)  lane i in bits [i*(PIX_W+2)+:PIX_W+2], signed; lane 0 is leftmost
wr_data  output  BUS_W  packed word; pixel k in bits [k*PIX_W+:PIX_W]
wr_addr  output  ADDR_W  byte address of wr_data
wr_en  output  1  write request; held until wr_ready
wr_ready  input  1  write accepted when wr_en&wr_ready
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final write is accepted

Behaviour:
- Reset: state IDLE; pix_ready, wr_en, busy, done = 0; wr_data, wr_addr = 0; accumulator, row and column counters cleared. Reset mid-frame abandons the frame with no further writes.
- PPW = BUS_W/PIX_W pixels per word; BPW = BUS_W/8 bytes per word.
- IDLE: on start, latch all configuration inputs. If blk_width==0 or blk_height==0, go to DONE. Otherwise go to RUN. start outside IDLE is ignored.
- RUN: pix_ready = !wr_en || wr_ready. An accepted beat appends IN_LANES pixels to the accumulator.
- A word completes when the accumulator holds PPW pixels, or when the row's last beat is accepted. A row-end word is zero-padded in the unfilled upper pixel slots.
- On completion, the word loads into the output register on the same edge: wr_en=1 next cycle, with wr_addr = base + row*stride + word_idx*BPW. Accumulator and word_idx clear at row end.
- Full throughput: one beat per cycle when wr_ready is held high. First wr_en appears one cycle after the completing beat.
- Output register: wr_data and wr_addr stay stable while wr_en && !wr_ready.
- After the last beat of the last row, go to DRAIN; pix_ready=0. When the final word is accepted, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Extra beats presented after the final beat are not accepted.
- Address arithmetic is modulo 2^ADDR_W. Row and column counters are DIM_W bits.

Optional Feature:
AV2_RECON_CLIP_EN
- Defined: each lane is clipped to [0, 2^PIX_W-1] before packing; negative values give 0, overflow gives all-ones.
- Undefined: each lane is truncated to its low PIX_W bits.
- Timing and handshake are identical in both builds.

Test Plan:
- 64×2, base 0x1000, stride 64, wr_ready=1, pixel value = column index -> 8 writes at 0x1000, 0x1010, 0x1020, 0x1030, 0x1040..0x1070; first word bytes 0..15; done one cycle after the 8th accept; 32 consecutive pix_ready cycles.
- 20×1, base 0 -> 2 writes at 0x0 and 0x10; second word holds pixels 16..19 in bytes 0..3 and zeros in bytes 4..15.
- 64×1 with wr_ready low for 5 cycles on the first write -> wr_data/wr_addr stable, pix_ready=0 during the stall, no word lost or duplicated, 4 writes total.
- blk_height=0 with start -> done pulses, wr_en never asserts, returns to IDLE.
- Lanes {-3, 300, 255, 7}, PIX_W=8 -> with AV2_RECON_CLIP_EN bytes are {0, 255, 255, 7}; without it bytes are {0xFD, 0x2C, 0xFF, 0x07}.
- rst_n pulled low after 2 writes of a 64×2 frame -> all outputs 0 immediately; a new start runs the full 8 writes correctly.
